// File: rtl/sr_pulse_driver.sv
`default_nettype none
// ============================================================================
//  Module      : sr_pulse_driver
//  Description : Debounces raw set/clear requests and drives one-cycle s/r
//                pulses into a downstream SR flip-flop. After each pulse it
//                checks the flip-flop feedback and raises a sticky error flag
//                on mismatch. A request held high yields exactly one pulse.
//                Optional auto-clear: define SR_PULSE_DRIVER_AUTOCLR_EN to
//                issue an r pulse HOLD_CYCLES cycles after a confirmed set.
//  Revision    : 1.0 - initial release
// ============================================================================
module sr_pulse_driver #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic set_req,
    input  logic clr_req,
    input  logic q_fb,
    output logic s,
    output logic r,
    output logic busy,
    output logic err
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DEB_SET   = 3'd1,
        DEB_CLR   = 3'd2,
        PULSE_SET = 3'd3,
        PULSE_CLR = 3'd4,
        CHECK     = 3'd5,
        WAIT_REL  = 3'd6
    } state_t;

    localparam logic [7:0] C_DEB_TARGET = 8'(DEBOUNCE_CYCLES);
    localparam logic [7:0] C_DEB_MAX    = 8'hFF;

    // Out-of-range configurations are rejected at elaboration.
    if ((DEBOUNCE_CYCLES < 1) || (DEBOUNCE_CYCLES > 255) ||
        (HOLD_CYCLES < 1) || (HOLD_CYCLES > 65535)) begin : g_param_check
        $error("sr_pulse_driver: DEBOUNCE_CYCLES or HOLD_CYCLES out of range");
    end

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_deb_cnt;
    logic [7:0] w_deb_cnt_next;
    logic [7:0] w_deb_inc;
    logic       w_deb_done;
    logic       w_first_done;
    logic       r_exp_q;
    logic       w_exp_q_next;
    logic       r_s;
    logic       r_r;
    logic       r_busy;
    logic       r_err;
    logic       w_err_next;
    logic       w_auto_clr;

    // Saturating increment: the counter parks at its maximum, never wraps.
    assign w_deb_inc    = (r_deb_cnt == C_DEB_MAX) ? C_DEB_MAX : (r_deb_cnt + 8'd1);
    assign w_deb_done   = (w_deb_inc >= C_DEB_TARGET);
    // With a one-cycle debounce the very first sample already qualifies.
    assign w_first_done = (C_DEB_TARGET <= 8'd1);

    // Next-state, debounce count, expected feedback and sticky error.
    always_comb begin
        w_state_next   = r_state;
        w_deb_cnt_next = r_deb_cnt;
        w_exp_q_next   = r_exp_q;
        w_err_next     = r_err;
        case (r_state)
            IDLE: begin
                if (w_auto_clr) begin
                    w_state_next   = PULSE_CLR;
                    w_deb_cnt_next = 8'd0;
                    w_exp_q_next   = 1'b0;
                end else if (clr_req) begin
                    if (w_first_done) begin
                        w_state_next   = PULSE_CLR;
                        w_deb_cnt_next = 8'd0;
                        w_exp_q_next   = 1'b0;
                    end else begin
                        w_state_next   = DEB_CLR;
                        w_deb_cnt_next = 8'd1;
                    end
                end else if (set_req) begin
                    if (w_first_done) begin
                        w_state_next   = PULSE_SET;
                        w_deb_cnt_next = 8'd0;
                        w_exp_q_next   = 1'b1;
                    end else begin
                        w_state_next   = DEB_SET;
                        w_deb_cnt_next = 8'd1;
                    end
                end
            end
            DEB_SET: begin
                if (clr_req) begin
                    // A clear request pre-empts a set in progress.
                    if (w_first_done) begin
                        w_state_next   = PULSE_CLR;
                        w_deb_cnt_next = 8'd0;
                        w_exp_q_next   = 1'b0;
                    end else begin
                        w_state_next   = DEB_CLR;
                        w_deb_cnt_next = 8'd1;
                    end
                end else if (!set_req) begin
                    w_state_next   = IDLE;
                    w_deb_cnt_next = 8'd0;
                end else if (w_deb_done) begin
                    w_state_next   = PULSE_SET;
                    w_deb_cnt_next = 8'd0;
                    w_exp_q_next   = 1'b1;
                end else begin
                    w_deb_cnt_next = w_deb_inc;
                end
            end
            DEB_CLR: begin
                // set_req has no influence while a clear is being debounced.
                if (!clr_req) begin
                    w_state_next   = IDLE;
                    w_deb_cnt_next = 8'd0;
                end else if (w_deb_done) begin
                    w_state_next   = PULSE_CLR;
                    w_deb_cnt_next = 8'd0;
                    w_exp_q_next   = 1'b0;
                end else begin
                    w_deb_cnt_next = w_deb_inc;
                end
            end
            PULSE_SET: begin
                w_state_next = CHECK;
            end
            PULSE_CLR: begin
                w_state_next = CHECK;
            end
            CHECK: begin
                if (q_fb != r_exp_q) begin
                    w_err_next = 1'b1;
                end
                w_state_next = WAIT_REL;
            end
            WAIT_REL: begin
                if (w_auto_clr) begin
                    w_state_next   = PULSE_CLR;
                    w_deb_cnt_next = 8'd0;
                    w_exp_q_next   = 1'b0;
                end else if (!set_req && !clr_req) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next   = IDLE;
                w_deb_cnt_next = 8'd0;
            end
        endcase
    end

    // State register; s/r/busy are registered from the next state so the
    // pulses are clean flop outputs aligned with PULSE_SET/PULSE_CLR.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_deb_cnt <= 8'd0;
            r_exp_q   <= 1'b0;
            r_s       <= 1'b0;
            r_r       <= 1'b0;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_deb_cnt <= w_deb_cnt_next;
            r_exp_q   <= w_exp_q_next;
            r_s       <= (w_state_next == PULSE_SET);
            r_r       <= (w_state_next == PULSE_CLR);
            r_busy    <= (w_state_next != IDLE);
            r_err     <= w_err_next;
        end
    end

`ifdef SR_PULSE_DRIVER_AUTOCLR_EN
    localparam logic [16:0] C_HOLD_TARGET = 17'(HOLD_CYCLES);
    localparam logic [15:0] C_HOLD_MAX    = 16'hFFFF;

    logic [15:0] r_hold_cnt;
    logic        r_hold_act;
    logic [16:0] w_hold_inc;
    logic        w_hold_confirm;
    logic        w_pulse_next;

    // The counter is 0 during the CHECK cycle and counts elapsed cycles after
    // it, so the auto-clear r lands HOLD_CYCLES cycles after CHECK.
    assign w_hold_confirm = (r_state == CHECK) && r_exp_q && q_fb;
    assign w_hold_inc     = {1'b0, r_hold_cnt} + 17'd1;
    assign w_auto_clr     = r_hold_act && (w_hold_inc >= C_HOLD_TARGET);
    assign w_pulse_next   = (w_state_next == PULSE_SET) || (w_state_next == PULSE_CLR);

    // Hold timer: any pulse restarts it; a confirmed set arms it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold_cnt <= 16'd0;
            r_hold_act <= 1'b0;
        end else if (w_pulse_next) begin
            r_hold_cnt <= 16'd0;
            r_hold_act <= 1'b0;
        end else if (r_hold_act || w_hold_confirm) begin
            if (r_hold_cnt != C_HOLD_MAX) begin
                r_hold_cnt <= w_hold_inc[15:0];
            end
            r_hold_act <= 1'b1;
        end
    end
`else
    assign w_auto_clr = 1'b0;
`endif

    assign s    = r_s;
    assign r    = r_r;
    assign busy = r_busy;
    assign err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sr_pulse_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sr_pulse_driver
//  Description : Directed scenarios plus randomized traffic for
//                sr_pulse_driver, compared every cycle against a behavioural
//                model built on request run lengths and cycle timestamps.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sr_pulse_driver;

    localparam int DEB  = 4;
    localparam int HOLD = 8;
`ifdef SR_PULSE_DRIVER_AUTOCLR_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    localparam int PH_IDLE  = 0;
    localparam int PH_PULSE = 1;
    localparam int PH_CHECK = 2;
    localparam int PH_WAIT  = 3;

    logic clk = 1'b0;
    logic reset;
    logic set_req;
    logic clr_req;
    logic q_fb;
    logic s;
    logic r;
    logic busy;
    logic err;

    int checks = 0;
    int errors = 0;

    // Model: phase of the command cycle, the request currently accumulating
    // (0 none, 1 set, 2 clear) and its run length, plus timestamps.
    int m_phase = PH_IDLE;
    int m_kind  = 0;
    int m_len   = 0;
    bit m_exp   = 1'b0;
    bit m_s     = 1'b0;
    bit m_r     = 1'b0;
    bit m_err   = 1'b0;
    bit m_hold_on = 1'b0;
    int m_t_conf  = 0;
    int cyc = 0;
    int sc  = 0;

    // Ideal SR flop fed back to the DUT, with optional faults.
    bit q_flop = 1'b0;
    bit q_tie0 = 1'b0;
    int corrupt_pct = 0;

    sr_pulse_driver #(
        .DEBOUNCE_CYCLES(DEB),
        .HOLD_CYCLES    (HOLD)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .set_req(set_req),
        .clr_req(clr_req),
        .q_fb   (q_fb),
        .s      (s),
        .r      (r),
        .busy   (busy),
        .err    (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic bit auto_due(input int n);
        return AUTO && m_hold_on && ((n + 1) >= (m_t_conf + HOLD));
    endfunction

    // Apply one rising edge to the model; n is the cycle that just ended.
    task automatic model_edge(input bit sr, input bit cr, input bit qf, input bit rst);
        bit fire_s;
        bit fire_r;
        int n;
        n = cyc;
        cyc++;
        fire_s = 1'b0;
        fire_r = 1'b0;
        if (rst) begin
            m_phase = PH_IDLE; m_kind = 0; m_len = 0; m_exp = 1'b0;
            m_s = 1'b0; m_r = 1'b0; m_err = 1'b0; m_hold_on = 1'b0;
            return;
        end
        case (m_phase)
            PH_IDLE: begin
                if (m_kind == 0 && auto_due(n)) begin
                    fire_r = 1'b1;
                end else begin
                    if (m_kind == 0) begin
                        if (cr)      begin m_kind = 2; m_len = 1; end
                        else if (sr) begin m_kind = 1; m_len = 1; end
                    end else if (m_kind == 1) begin
                        if (cr)      begin m_kind = 2; m_len = 1; end
                        else if (sr) m_len = (m_len < 255) ? m_len + 1 : 255;
                        else         begin m_kind = 0; m_len = 0; end
                    end else begin
                        if (cr) m_len = (m_len < 255) ? m_len + 1 : 255;
                        else    begin m_kind = 0; m_len = 0; end
                    end
                    if (m_kind != 0 && m_len >= DEB) begin
                        fire_s = (m_kind == 1);
                        fire_r = (m_kind == 2);
                    end
                end
            end
            PH_PULSE: m_phase = PH_CHECK;
            PH_CHECK: begin
                if (qf != m_exp) m_err = 1'b1;
                if (AUTO && m_exp && qf) begin
                    m_hold_on = 1'b1;
                    m_t_conf  = n;
                end
                m_phase = PH_WAIT;
            end
            default: begin
                if (auto_due(n))      fire_r = 1'b1;
                else if (!sr && !cr)  m_phase = PH_IDLE;
            end
        endcase
        m_s = fire_s;
        m_r = fire_r;
        if (fire_s || fire_r) begin
            m_phase = PH_PULSE; m_kind = 0; m_len = 0;
            m_exp = fire_s; m_hold_on = 1'b0;
        end
    endtask

    // One clock cycle: drive inputs, advance the model, compare all outputs.
    task automatic step(input bit sr, input bit cr, input bit rst);
        bit qf;
        bit bad;
        @(negedge clk);
        qf = q_tie0 ? 1'b0 : q_flop;
        set_req = sr; clr_req = cr; reset = rst; q_fb = qf;
        @(posedge clk);
        bad = ($urandom_range(99) < corrupt_pct);
        if (!bad && m_s) q_flop = 1'b1;
        if (!bad && m_r) q_flop = 1'b0;
        model_edge(sr, cr, qf, rst);
        sc++;
        #1;
        chk("s", s, m_s);
        chk("r", r, m_r);
        chk("busy", busy, (m_phase != PH_IDLE) || (m_kind != 0));
        chk("err", err, m_err);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        bit p34 [12] = '{1, 1, 0, 1, 1, 1, 1, 1, 1, 1, 0, 0};
        bit rs;
        bit rc;
        int nr;
        set_req = 1'b0; clr_req = 1'b0; reset = 1'b1; q_fb = 1'b0;

        // Reset state.
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        chk("rst_s", s, 1'b0);
        chk("rst_r", r, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err, 1'b0);
        idle(3);

        // Held set request: single s in cycle 4, busy cycles 1..7.
        sc = 0;
        for (int i = 0; i < 11; i++) begin
            step(i < 7, 1'b0, 1'b0);
            chk("set_s", s, sc == 4);
            chk("set_r", r, 1'b0);
            chk("set_busy", busy, (sc >= 1) && (sc <= 7));
        end
        idle(20);

        // Bouncing set: first run aborts, pulse 4 cycles after second rise.
        sc = 0;
        for (int i = 0; i < 12; i++) begin
            step(p34[i], 1'b0, 1'b0);
            chk("bounce_s", s, sc == 7);
            if (sc == 3) chk("bounce_abort_busy", busy, 1'b0);
        end
        idle(20);

        // Both requests high: clear wins.
        sc = 0;
        for (int i = 0; i < 10; i++) begin
            step(i < 8, i < 8, 1'b0);
            chk("both_s", s, 1'b0);
            chk("both_r", r, sc == 4);
        end
        idle(20);

        // Reset in the edge that would launch s; pulse restarts afterwards.
        sc = 0;
        for (int i = 0; i < 13; i++) begin
            step(i < 11, 1'b0, i == 3);
            chk("rstpulse_s", s, sc == 8);
            if (sc == 4) chk("rstpulse_busy", busy, 1'b0);
        end
        idle(20);

        // Feedback stuck low: err from the cycle after CHECK, until reset.
        q_tie0 = 1'b1;
        sc = 0;
        for (int i = 0; i < 10; i++) begin
            step(i < 6, 1'b0, 1'b0);
            chk("stuck_err", err, sc >= 6);
        end
        idle(3);
        chk("stuck_err_hold", err, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        chk("stuck_err_clr", err, 1'b0);
        q_tie0 = 1'b0;
        idle(3);

`ifdef SR_PULSE_DRIVER_AUTOCLR_EN
        // Auto-clear: CHECK in cycle 5, r exactly once in cycle 5+HOLD.
        sc = 0;
        nr = 0;
        for (int i = 0; i < 22; i++) begin
            step(i < 5, 1'b0, 1'b0);
            chk("auto_r", r, sc == 5 + HOLD);
            if (r === 1'b1) nr++;
        end
        chk("auto_r_once", nr == 1, 1'b1);
        idle(5);
`endif

        // Randomized traffic with occasional feedback faults and resets.
        corrupt_pct = 10;
        rs = 1'b0;
        rc = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(4) == 0) rs = ~rs;
            if ($urandom_range(5) == 0) rc = ~rc;
            step(rs, rc, $urandom_range(299) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sr_pulse_driver.md
SR_PULSE_DRIVER -- requirements
Module: sr_pulse_driver

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 4, consecutive stable request cycles required before a command is issued (range 1..255).
REQ-002 The block SHALL have parameter HOLD_CYCLES, default 16, cycles a confirmed set state is held before auto-clear (range 1..65535, used only under REQ-030).
REQ-003 The block SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port set_req  input  1  raw set request (level, may bounce).
REQ-006 The block SHALL have port clr_req  input  1  raw clear request (level, may bounce).
REQ-007 The block SHALL have port q_fb  input  1  q output of the downstream SR flip-flop it drives.
REQ-008 The block SHALL have port s  output  1  set pulse to the flip-flop.
REQ-009 The block SHALL have port r  output  1  reset pulse to the flip-flop.
REQ-010 The block SHALL have port busy  output  1  high whenever the FSM is not in IDLE.
REQ-011 The block SHALL have port err  output  1  sticky feedback-mismatch flag.

Function
REQ-012 The FSM SHALL have states IDLE, DEB_SET, DEB_CLR, PULSE_SET, PULSE_CLR, CHECK, WAIT_REL.
REQ-013 In IDLE, clr_req=1 SHALL go to DEB_CLR with debounce count 1; else set_req=1 SHALL go to DEB_SET with count 1; clr_req wins if both are high.
REQ-014 In DEB_SET, set_req=0 SHALL return to IDLE with count cleared, and clr_req=1 SHALL go to DEB_CLR with count 1.
REQ-015 In DEB_CLR, clr_req=0 SHALL return to IDLE with count cleared, and set_req is ignored.
REQ-016 When count reaches DEBOUNCE_CYCLES with the request still high, the FSM SHALL go to PULSE_SET/PULSE_CLR, so s (or r) is high exactly in cycle k+DEBOUNCE_CYCLES, where k is the first cycle the request was sampled high.
REQ-017 s and r SHALL each be high for exactly one cycle per command and SHALL never be high in the same cycle.
REQ-018 After a pulse, the FSM SHALL enter CHECK for one cycle, compare q_fb to the expected value (1 after set, 0 after clear), and set err=1 on mismatch.
REQ-019 From CHECK, the FSM SHALL go to WAIT_REL, and stay there until set_req=0 and clr_req=0 are sampled in the same cycle, then go to IDLE.
REQ-020 A request held high continuously SHALL therefore produce exactly one pulse.
REQ-021 The debounce counter SHALL be 8 bits and SHALL saturate, never wrapping.
REQ-022 err SHALL stay high until reset and SHALL NOT affect FSM sequencing.
REQ-023 s and r SHALL be registered outputs, not decoded combinationally from inputs.

Reset
REQ-024 With reset=1 at a rising edge, the next state SHALL be IDLE, with s=0, r=0, busy=0, err=0, and all counters 0.
REQ-025 Reset SHALL take priority over every other event, including a pulse in flight; a pulse cycle coinciding with reset SHALL drive s=0 and r=0.
REQ-026 After reset deasserts, a request already high SHALL be debounced from count 1; no pulse SHALL be issued earlier than DEBOUNCE_CYCLES cycles later.

Configuration
REQ-027 The macro SR_PULSE_DRIVER_AUTOCLR_EN SHALL control the auto-clear feature.
REQ-028 Without the macro, no hold counter SHALL exist and r SHALL be issued only per REQ-016.
REQ-029 With the macro, a 16-bit hold counter SHALL start at 0 when CHECK confirms q_fb=1 after a set, and SHALL increment each cycle while the last confirmed command is set.
REQ-030 When the hold counter reaches HOLD_CYCLES with the FSM in IDLE or WAIT_REL, the FSM SHALL go to PULSE_CLR, issuing r for one cycle followed by the normal CHECK.
REQ-031 If the FSM is in any other state when the hold counter reaches HOLD_CYCLES, the auto-clear SHALL wait until the FSM returns to IDLE or WAIT_REL.
REQ-032 Any s or r pulse and reset SHALL clear the hold counter.

Verification
REQ-033 With DEBOUNCE_CYCLES=4, set_req high from cycle 0, and q_fb following s one cycle later -> s=1 only in cycle 4; r=0 throughout; err=0; busy=1 from cycle 1 until the cycle after set_req falls.
REQ-034 With set_req toggled 1,1,0,1,1,1,1 -> the first run aborts to IDLE, and s=1 occurs exactly 4 cycles after the second rise.
REQ-035 With set_req=1 and clr_req=1 from cycle 0 -> r=1 in cycle 4 and s is never asserted.
REQ-036 With set_req high, then reset=1 in the cycle s would assert -> s stays 0 and state=IDLE; the pulse occurs 4 cycles after reset deasserts if set_req remains high.
REQ-037 With q_fb tied to 0 and a set command issued -> err=1 from the cycle after CHECK and held until reset.
REQ-038 With AUTOCLR_EN defined, HOLD_CYCLES=8, and a set confirmed with all requests released -> r=1 exactly once, 8 cycles after the CHECK cycle.
